// File: rtl/rv32im_trap_ctrl_pkg.sv
// rtl/rv32im_trap_ctrl_pkg.sv - shared CSR addresses, mstatus fields, cause codes and FSM states
package rv32im_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [4:0] CAUSE_MEI = 5'd11;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MSI = 5'd3;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_T_EPC    = 4'd1,
        ST_T_CAUSE  = 4'd2,
        ST_T_TVAL   = 4'd3,
        ST_T_STATUS = 4'd4,
        ST_T_VEC    = 4'd5,
        ST_R_EPC    = 4'd6,
        ST_R_STATUS = 4'd7,
        ST_REDIR    = 4'd8
    } trap_state_e;

endpackage

// File: rtl/rv32im_trap_ctrl_irq_prio.sv
// rtl/rv32im_trap_ctrl_irq_prio.sv - fixed-priority encoder for machine interrupts (MEI > MSI > MTI)
module rv32im_irq_prio
    import rv32im_trap_ctrl_pkg::*;
(
    input  logic [31:0] pend,
    output logic        valid,
    output logic [4:0]  code
);

    logic unused_pend;
    assign unused_pend = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        valid = 1'b1;
        code  = CAUSE_MEI;
        if (pend[11]) begin
            code = CAUSE_MEI;
        end else if (pend[3]) begin
            code = CAUSE_MSI;
        end else if (pend[7]) begin
            code = CAUSE_MTI;
        end else begin
            valid = 1'b0;
            code  = 5'd0;
        end
    end

endmodule

// File: rtl/rv32im_trap_ctrl.sv
// rtl/rv32im_trap_ctrl.sv - machine-mode trap/MRET sequencer and CSR port arbiter
module rv32im_trap_ctrl
    import rv32im_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              exc_valid_i,
    input  logic [3:0]        exc_cause_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic [XLEN-1:0]   exc_tval_i,
    input  logic              mret_valid_i,
    input  logic [XLEN-1:0]   irq_i,
    input  logic              irq_ok_i,
    input  logic [XLEN-1:0]   irq_pc_i,
    input  logic [XLEN-1:0]   csr_status_i,
    input  logic [XLEN-1:0]   csr_mie_i,
    input  logic              pipe_csr_req_i,
    input  logic              pipe_csr_we_i,
    input  logic [CSR_AW-1:0] pipe_csr_addr_i,
    input  logic [XLEN-1:0]   pipe_csr_wdata_i,
    output logic              pipe_csr_gnt_o,
    output logic [XLEN-1:0]   pipe_csr_rdata_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic              csr_write_en_o,
    output logic              csr_read_en_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              trap_ack_o,
    output logic              trap_br_o,
    output logic [XLEN-1:0]   trap_target_o,
    output logic              busy_o
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:2] epc_q;
    logic [XLEN-1:0] cause_q, tval_q, target_q;

    logic [XLEN-1:0] irq_pend;
    logic            irq_valid;
    logic [4:0]      irq_code;

    assign irq_pend = irq_i & csr_mie_i & IRQ_MASK;

    rv32im_irq_prio u_irq_prio (
        .pend  (irq_pend),
        .valid (irq_valid),
        .code  (irq_code)
    );

    // Gating with rst_n_i keeps every combinational output low while reset is held.
    logic idle, take_exc, take_mret, take_irq, event_sel, gnt;
    assign idle      = rst_n_i && (state_q == ST_IDLE);
    assign take_exc  = idle && exc_valid_i;
    assign take_mret = idle && !exc_valid_i && mret_valid_i;
    assign take_irq  = idle && !exc_valid_i && !mret_valid_i && irq_ok_i
                       && csr_status_i[MSTATUS_MIE] && irq_valid;
    assign event_sel = take_exc || take_mret || take_irq;
    assign gnt       = idle && pipe_csr_req_i && !event_sel;

    logic [XLEN-1:0] status_trap, status_mret, vec_base, vec_target;

    always_comb begin
        status_trap                               = csr_status_i;
        status_trap[MSTATUS_MPIE]                 = csr_status_i[MSTATUS_MIE];
        status_trap[MSTATUS_MIE]                  = 1'b0;
        status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        status_mret                               = csr_status_i;
        status_mret[MSTATUS_MIE]                  = csr_status_i[MSTATUS_MPIE];
        status_mret[MSTATUS_MPIE]                 = 1'b1;
        status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign vec_base   = {csr_rdata_i[XLEN-1:2], 2'b00};
    assign vec_target = (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1])
                        ? vec_base + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00}
                        : vec_base;

    always_comb begin
        state_d          = state_q;
        pipe_csr_gnt_o   = 1'b0;
        pipe_csr_rdata_o = '0;
        csr_addr_o       = '0;
        csr_write_en_o   = 1'b0;
        csr_read_en_o    = 1'b0;
        csr_wdata_o      = '0;
        trap_ack_o       = 1'b0;
        trap_br_o        = 1'b0;
        trap_target_o    = '0;

        case (state_q)
            ST_IDLE: begin
                trap_ack_o = event_sel;
                if (take_exc || take_irq) begin
                    state_d = ST_T_EPC;
                end else if (take_mret) begin
                    state_d = ST_R_EPC;
                end
                if (gnt) begin
                    pipe_csr_gnt_o   = 1'b1;
                    pipe_csr_rdata_o = csr_rdata_i;
                    csr_addr_o       = pipe_csr_addr_i;
                    csr_write_en_o   = pipe_csr_we_i;
                    csr_read_en_o    = !pipe_csr_we_i;
                    csr_wdata_o      = pipe_csr_wdata_i;
                end
            end
            ST_T_EPC: begin
                csr_addr_o     = CSR_MEPC;
                csr_write_en_o = 1'b1;
                csr_wdata_o    = {epc_q, 2'b00};
                state_d        = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                csr_addr_o     = CSR_MCAUSE;
                csr_write_en_o = 1'b1;
                csr_wdata_o    = cause_q;
                state_d        = ST_T_TVAL;
            end
            ST_T_TVAL: begin
                csr_addr_o     = CSR_MTVAL;
                csr_write_en_o = 1'b1;
                csr_wdata_o    = tval_q;
                state_d        = ST_T_STATUS;
            end
            ST_T_STATUS: begin
                csr_addr_o     = CSR_MSTATUS;
                csr_write_en_o = 1'b1;
                csr_wdata_o    = status_trap;
                state_d        = ST_T_VEC;
            end
            ST_T_VEC: begin
                csr_addr_o    = CSR_MTVEC;
                csr_read_en_o = 1'b1;
                state_d       = ST_REDIR;
            end
            ST_R_EPC: begin
                csr_addr_o    = CSR_MEPC;
                csr_read_en_o = 1'b1;
                state_d       = ST_R_STATUS;
            end
            ST_R_STATUS: begin
                csr_addr_o     = CSR_MSTATUS;
                csr_write_en_o = 1'b1;
                csr_wdata_o    = status_mret;
                state_d        = ST_REDIR;
            end
            ST_REDIR: begin
                trap_br_o     = 1'b1;
                trap_target_o = target_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (take_exc) begin
                epc_q   <= exc_pc_i[XLEN-1:2];
                cause_q <= {{(XLEN-4){1'b0}}, exc_cause_i};
                tval_q  <= exc_tval_i;
            end else if (take_irq) begin
                epc_q   <= irq_pc_i[XLEN-1:2];
                cause_q <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
                tval_q  <= '0;
            end
            if (state_q == ST_T_VEC) begin
                target_q <= vec_target;
            end else if (state_q == ST_R_EPC) begin
                target_q <= csr_rdata_i;
            end
        end
    end

    logic unused_exc_pc;
    assign unused_exc_pc = ^{exc_pc_i[1:0], irq_pc_i[1:0]};

endmodule
